// File: rtl/rf_bypass_2w.sv
// rtl/rf_bypass_2w.sv - DEPTH x WIDTH register file, 2 combinational reads, 2 synchronous writes
// Optional write-to-read bypass, hardwired zero register and a registered error flag.
module rf_bypass_2w #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int AW       = 3,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    read1regsel,
   input  logic [AW-1:0]    read2regsel,
   input  logic [AW-1:0]    write0regsel,
   input  logic [WIDTH-1:0] write0data,
   input  logic             write0,
   input  logic [AW-1:0]    write1regsel,
   input  logic [WIDTH-1:0] write1data,
   input  logic             write1,
   output logic [WIDTH-1:0] read1data,
   output logic [WIDTH-1:0] read2data,
   output logic             err
);
   localparam bit HAS_ZERO   = (ZERO_REG != 0);
   localparam bit HAS_BYPASS = (BYPASS != 0);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             r1_in, r2_in, w0_in, w1_in;
   logic             r1_ok, r2_ok, w0_ok, w1_ok;
   logic             collision, bad_sel, err_next;
   logic [WIDTH-1:0] stored1, stored2;

   // Range checks only exist when the select can address past the last register.
   generate
      if (DEPTH < (1 << AW)) begin : g_oor
         localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
         assign r1_in = (read1regsel <= LAST);
         assign r2_in = (read2regsel <= LAST);
         assign w0_in = (write0regsel <= LAST);
         assign w1_in = (write1regsel <= LAST);
      end else begin : g_full
         assign r1_in = 1'b1;
         assign r2_in = 1'b1;
         assign w0_in = 1'b1;
         assign w1_in = 1'b1;
      end
   endgenerate

   assign r1_ok = r1_in && !(HAS_ZERO && read1regsel == '0);
   assign r2_ok = r2_in && !(HAS_ZERO && read2regsel == '0);
   assign w0_ok = write0 && w0_in && !(HAS_ZERO && write0regsel == '0);
   assign w1_ok = write1 && w1_in && !(HAS_ZERO && write1regsel == '0);

   assign collision = w0_ok && w1_ok && (write0regsel == write1regsel);
   assign bad_sel   = (write0 && !w0_in) || (write1 && !w1_in) || !r1_in || !r2_in;
   assign err_next  = collision || bad_sel;

   always_comb begin
      stored1 = '0;
      stored2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (read1regsel == AW'(i)) stored1 = regs[i];
         if (read2regsel == AW'(i)) stored2 = regs[i];
      end
   end

   // Port 1 wins over port 0 when both target the read select.
   always_comb begin
      read1data = '0;
      if (rst && r1_ok) begin
         if (HAS_BYPASS && w1_ok && write1regsel == read1regsel)
            read1data = write1data;
         else if (HAS_BYPASS && w0_ok && write0regsel == read1regsel)
            read1data = write0data;
         else
            read1data = stored1;
      end
   end

   always_comb begin
      read2data = '0;
      if (rst && r2_ok) begin
         if (HAS_BYPASS && w1_ok && write1regsel == read2regsel)
            read2data = write1data;
         else if (HAS_BYPASS && w0_ok && write0regsel == read2regsel)
            read2data = write0data;
         else
            read2data = stored2;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         err <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w1_ok && write1regsel == AW'(i))
               regs[i] <= write1data;
            else if (w0_ok && write0regsel == AW'(i))
               regs[i] <= write0data;
         end
         err <= err_next;
      end
   end
endmodule

// File: tb/tb_rf_bypass_2w.sv
// tb/tb_rf_bypass_2w.sv - Self-checking bench for rf_bypass_2w
// Instance a: defaults (8 regs, bypass). Instance b: 6 regs, no bypass, zero register.
module tb_rf_bypass_2w;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  read1regsel, read2regsel, write0regsel, write1regsel;
   logic [15:0] write0data, write1data;
   logic        write0, write1;
   logic [15:0] r1_a, r2_a, r1_b, r2_b;
   logic        err_a, err_b;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] ma [8];
   logic [15:0] mb [8];

   typedef struct {
      logic w0; logic [2:0] w0s; logic [15:0] w0d;
      logic w1; logic [2:0] w1s; logic [15:0] w1d;
      logic [2:0] r1s; logic [2:0] r2s;
      logic [15:0] e1; logic [15:0] e2; logic eerr;
   } vec_t;
   vec_t tbl [10];

   always #5 clk = ~clk;

   rf_bypass_2w dut_a (
      .clk(clk), .rst(rst),
      .read1regsel(read1regsel), .read2regsel(read2regsel),
      .write0regsel(write0regsel), .write0data(write0data), .write0(write0),
      .write1regsel(write1regsel), .write1data(write1data), .write1(write1),
      .read1data(r1_a), .read2data(r2_a), .err(err_a)
   );

   rf_bypass_2w #(.WIDTH(16), .DEPTH(6), .AW(3), .BYPASS(0), .ZERO_REG(1)) dut_b (
      .clk(clk), .rst(rst),
      .read1regsel(read1regsel), .read2regsel(read2regsel),
      .write0regsel(write0regsel), .write0data(write0data), .write0(write0),
      .write1regsel(write1regsel), .write1data(write1data), .write1(write1),
      .read1data(r1_b), .read2data(r2_b), .err(err_b)
   );

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic bit sel_ok(int depth, bit zr, logic [2:0] s);
      return (int'(s) < depth) && !(zr && s == 3'd0);
   endfunction

   function automatic logic [15:0] exp_read(int depth, bit byp, bit zr,
                                            logic [15:0] m [8], logic [2:0] rs);
      if (!rst || !sel_ok(depth, zr, rs)) return 16'h0;
      if (byp && write1 && write1regsel == rs) return write1data;
      if (byp && write0 && write0regsel == rs) return write0data;
      return m[rs];
   endfunction

   function automatic bit exp_err(int depth, bit zr);
      bit bad;
      bit col;
      bad = (int'(read1regsel) >= depth) || (int'(read2regsel) >= depth) ||
            (write0 && int'(write0regsel) >= depth) || (write1 && int'(write1regsel) >= depth);
      col = write0 && write1 && (write0regsel == write1regsel) && sel_ok(depth, zr, write0regsel);
      return bad || col;
   endfunction

   task automatic drive(logic w0, logic [2:0] w0s, logic [15:0] w0d,
                        logic w1, logic [2:0] w1s, logic [15:0] w1d,
                        logic [2:0] r1s, logic [2:0] r2s);
      write0 = w0; write0regsel = w0s; write0data = w0d;
      write1 = w1; write1regsel = w1s; write1data = w1d;
      read1regsel = r1s; read2regsel = r2s;
   endtask

   task automatic clear_models();
      for (int i = 0; i < 8; i++) begin
         ma[i] = 16'h0;
         mb[i] = 16'h0;
      end
   endtask

   // Called just after a rising edge with inputs applied; checks reads, clocks, checks err.
   task automatic step(string tag, bit use_tbl, logic [15:0] e1, logic [15:0] e2, logic eerr);
      logic ea, eb;
      #2;
      if (use_tbl) begin
         chk({tag, " a.read1"}, r1_a, e1);
         chk({tag, " a.read2"}, r2_a, e2);
      end else begin
         chk({tag, " a.read1"}, r1_a, exp_read(8, 1'b1, 1'b0, ma, read1regsel));
         chk({tag, " a.read2"}, r2_a, exp_read(8, 1'b1, 1'b0, ma, read2regsel));
      end
      chk({tag, " b.read1"}, r1_b, exp_read(6, 1'b0, 1'b1, mb, read1regsel));
      chk({tag, " b.read2"}, r2_b, exp_read(6, 1'b0, 1'b1, mb, read2regsel));
      ea = use_tbl ? eerr : exp_err(8, 1'b0);
      eb = exp_err(6, 1'b1);
      if (write0 && sel_ok(8, 1'b0, write0regsel)) ma[write0regsel] = write0data;
      if (write1 && sel_ok(8, 1'b0, write1regsel)) ma[write1regsel] = write1data;
      if (write0 && sel_ok(6, 1'b1, write0regsel)) mb[write0regsel] = write0data;
      if (write1 && sel_ok(6, 1'b1, write1regsel)) mb[write1regsel] = write1data;
      @(posedge clk);
      #1;
      chk({tag, " a.err"}, {15'h0, err_a}, {15'h0, ea});
      chk({tag, " b.err"}, {15'h0, err_b}, {15'h0, eb});
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 3'd1, 3'd2);
      clear_models();
      #2;
      chk("reset a.read1", r1_a, 16'h0);
      chk("reset a.read2", r2_a, 16'h0);
      chk("reset b.read1", r1_b, 16'h0);
      chk("reset a.err", {15'h0, err_a}, 16'h0);
      chk("reset b.err", {15'h0, err_b}, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      tbl[0] = '{1'b1, 3'd5, 16'hA5A5, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 16'hA5A5, 16'h0000, 1'b0};
      tbl[1] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 16'hA5A5, 16'hA5A5, 1'b0};
      tbl[2] = '{1'b1, 3'd2, 16'h1111, 1'b1, 3'd2, 16'h2222, 3'd2, 3'd2, 16'h2222, 16'h2222, 1'b1};
      tbl[3] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 16'h2222, 16'hA5A5, 1'b0};
      tbl[4] = '{1'b1, 3'd1, 16'h0F0F, 1'b1, 3'd6, 16'hF0F0, 3'd1, 3'd6, 16'h0F0F, 16'hF0F0, 1'b0};
      tbl[5] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd6, 16'h0F0F, 16'hF0F0, 1'b0};
      tbl[6] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd3, 16'hFFFF, 16'h0000, 1'b0};
      tbl[7] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'hFFFF, 16'h0000, 1'b0};
      tbl[8] = '{1'b1, 3'd7, 16'h1234, 1'b1, 3'd7, 16'h4321, 3'd7, 3'd2, 16'h4321, 16'h2222, 1'b1};
      tbl[9] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd3, 16'h4321, 16'h0000, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].w0, tbl[i].w0s, tbl[i].w0d, tbl[i].w1, tbl[i].w1s, tbl[i].w1d,
               tbl[i].r1s, tbl[i].r2s);
         step($sformatf("vec%0d", i), 1'b1, tbl[i].e1, tbl[i].e2, tbl[i].eerr);
      end

      // Out-of-range write and read on the 6-entry instance.
      drive(1, 3'd7, 16'h1234, 0, 0, 0, 3'd7, 3'd6);
      #1;
      chk("oor b.read1", r1_b, 16'h0);
      chk("oor b.read2", r2_b, 16'h0);
      step("oor", 1'b0, 0, 0, 0);
      chk("oor b.err pulse", {15'h0, err_b}, 16'h1);

      // Zero register writes are discarded silently.
      drive(0, 0, 0, 1, 3'd0, 16'hFFFF, 3'd0, 3'd1);
      #1;
      chk("zero b.read1 before", r1_b, 16'h0);
      step("zero", 1'b0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 3'd0, 3'd1);
      #1;
      chk("zero b.read1 after", r1_b, 16'h0);
      chk("zero b.err", {15'h0, err_b}, 16'h0);
      chk("zero a.read1 after", r1_a, 16'hFFFF);

      // Without bypass the new value appears only after the edge.
      drive(1, 3'd4, 16'h5A5A, 0, 0, 0, 3'd4, 3'd4);
      #1;
      chk("nobyp b.read1 before", r1_b, 16'h0);
      chk("byp a.read1 before", r1_a, 16'h5A5A);
      step("nobyp", 1'b0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 3'd4, 3'd4);
      #1;
      chk("nobyp b.read1 after", r1_b, 16'h5A5A);

      // Asynchronous reset mid-run, with an err pulse in flight.
      drive(1, 3'd3, 16'hBEEF, 0, 0, 0, 3'd3, 3'd3);
      step("ld3", 1'b0, 0, 0, 0);
      drive(1, 3'd1, 16'h7777, 1, 3'd1, 16'h8888, 3'd3, 3'd1);
      step("col1", 1'b0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 3'd3, 3'd3);
      #1;
      chk("pre-reset a.read1", r1_a, 16'hBEEF);
      chk("pre-reset a.err", {15'h0, err_a}, 16'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("async a.read1", r1_a, 16'h0);
      chk("async a.read2", r2_a, 16'h0);
      chk("async a.err", {15'h0, err_a}, 16'h0);
      clear_models();
      drive(1, 3'd3, 16'h5555, 0, 0, 0, 3'd3, 3'd1);
      @(posedge clk);
      #1;
      chk("in-reset a.read1", r1_a, 16'h0);
      chk("in-reset a.err", {15'h0, err_a}, 16'h0);
      rst = 1'b1;
      drive(1, 3'd3, 16'h0001, 0, 0, 0, 3'd3, 3'd1);
      step("post-reset", 1'b0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 3'd3, 3'd1);
      #1;
      chk("post-reset a.read1", r1_a, 16'h0001);
      chk("post-reset a.read2", r2_a, 16'h0);
      chk("post-reset b.read1", r1_b, 16'h0001);

      for (int n = 0; n < 300; n++) begin
         logic [2:0] s0;
         s0 = 3'($urandom_range(0, 7));
         drive(1'($urandom_range(0, 1)), s0, 16'($urandom),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? s0 : 3'($urandom_range(0, 7)), 16'($urandom),
               ($urandom_range(0, 2) == 0) ? s0 : 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)));
         step($sformatf("rnd%0d", n), 1'b0, 0, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rf_bypass_2w.md
Name: rf_bypass_2w

Overview:
- Parametrised successor to the team's 8x16 bypassing register file.
- Provides DEPTH registers of WIDTH bits, two combinational read ports and two synchronous write ports.
- Optional write-to-read bypass and an optional hardwired-zero register 0.
- Registered err flag reports write collisions and out-of-range selects; sits in the decode stage of the pipelined CPU.

Parameters:
WIDTH, 16, data width of each register and data port
DEPTH, 8, number of registers, 2..2**AW, need not be a power of two
AW, 3, select width, must satisfy 2**AW >= DEPTH
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only
ZERO_REG, 0, 1 = register 0 always reads 0 and writes to it are discarded without error

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
read1regsel  in  AW  read port 1 select
read2regsel  in  AW  read port 2 select
write0regsel  in  AW  write port 0 select
write0data  in  WIDTH  write port 0 data
write0  in  1  write port 0 enable
write1regsel  in  AW  write port 1 select
write1data  in  WIDTH  write port 1 data
write1  in  1  write port 1 enable; has priority over port 0
read1data  out  WIDTH  read port 1 data, combinational
read2data  out  WIDTH  read port 2 data, combinational
err  out  1  registered error flag, one-cycle pulse per offending cycle

Behaviour:
- Reset: rst low clears every register to 0 and err to 0 immediately, without waiting for clk. While rst is low, writes are ignored, bypass is suppressed and both read ports output 0.
- Write: on the rising edge, port p with writeN=1 and a valid select (< DEPTH, and not 0 when ZERO_REG=1) loads writeNdata into the selected register.
- Collision: both ports enabled with the same valid select -> only write1data is stored; err=1 after that edge.
- Read: readNdata = register[readNregsel], combinational, zero latency.
- Bypass (BYPASS=1): forwarding is resolved in this priority order:
  - If write1=1 with a valid select equal to readNregsel, readNdata = write1data in the same cycle.
  - Otherwise, if write0 matches in the same way, readNdata = write0data.
  - Otherwise the stored value is read.
- With BYPASS=0, the new value is visible from the cycle after the edge.
- ZERO_REG=1: reads of select 0 return 0 regardless of bypass. Writes to 0 are dropped, do not bypass and do not raise err.
- Out-of-range (select >= DEPTH, only possible when DEPTH < 2**AW):
  - An enabled write with an out-of-range select is dropped, does not bypass, and sets err=1 after the edge.
  - A read with an out-of-range select returns 0 and sets err=1 after the edge.
- err: err_next = collision | bad write select | bad read1 select | bad read2 select, registered on clk. err holds 1 for exactly one cycle per offending cycle.
- Out-of-range errors are only detectable when DEPTH < 2**AW. Otherwise err is driven only by collisions.
- Simultaneous read and write to the same register with BYPASS=1 and no error: the read sees the new data in that cycle, and the register holds it afterwards.
- Reset asserted in the same cycle as writes: the writes are lost and the registers stay 0 until rst is released.
- The first write is honoured at the first rising edge after rst goes high.

Test Plan:
- Reset: drive rst=0 mid-run after loading reg3=16'hBEEF -> read1data (sel 3) drops to 0 asynchronously and err=0. Release rst and write reg3=16'h0001 at the next edge -> reads 16'h0001.
- Bypass: write0=1, sel 5, data 16'hA5A5; read1regsel=5 in the same cycle -> read1data=16'hA5A5 before the edge. After the edge with write0=0 -> still 16'hA5A5. With BYPASS=0 -> old value 0 before the edge, 16'hA5A5 after.
- Collision: write0 sel 2 data 16'h1111 and write1 sel 2 data 16'h2222 together, read2regsel=2 -> read2data=16'h2222 that cycle; reg2=16'h2222 after the edge; err=1 for one cycle, then 0.
- Dual write: write0 sel 1 = 16'h0F0F and write1 sel 6 = 16'hF0F0 in one cycle -> next cycle read1(sel 1)=16'h0F0F and read2(sel 6)=16'hF0F0; err stays 0.
- ZERO_REG=1: write1 sel 0 data 16'hFFFF -> read1(sel 0)=0 both before and after the edge; err=0.
- Out of range (DEPTH=6, AW=3): write0 sel 7 data 16'h1234 -> no register changes and err=1 next cycle. read2regsel=6 -> read2data=0 and err=1 next cycle.
